bus_arbiter: RTL

- Round-robin arbiter for the 4-master shared bus.
- Takes active-low requests from masters m0..m3 and drives the active-low grant lines that the master-side multiplexer uses to route the chosen master to the slaves.
- Holds ownership while a master is mid-transfer.
- Revokes ownership after a slave-ready timeout and flags a bus error.

---
 rtl/bus_arbiter_pkg.sv | 33 +++
 rtl/bus_arb_rr_pick.sv | 40 ++++
 rtl/bus_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : Shared definitions for the 4-master shared-bus arbiter.
//                Active-low enable levels, master channel count and index
//                width, arbiter state encodings and a one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    // Active-low bus signalling levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int BUS_MASTER_CH      = 4;
    localparam int BUS_MASTER_INDEX_W = 2;

    typedef enum logic [0:0] {
        BUS_ARB_IDLE  = 1'b0,
        BUS_ARB_GRANT = 1'b1
    } bus_arb_state_e;

    // One-hot decode of a master index
    function automatic logic [BUS_MASTER_CH-1:0] bus_onehot(
        input logic [BUS_MASTER_INDEX_W-1:0] idx
    );
        logic [BUS_MASTER_CH-1:0] one;
        one = {{(BUS_MASTER_CH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_rr_pick
//  Description : Combinational round-robin picker. Scans the eligible vector
//                in the order start+1, start+2, start+3, start (mod 4) and
//                returns the first eligible master.
//  Ports       : i_elig   [4]  eligible masters (active high)
//                i_start  [2]  round-robin pointer (last owner)
//                o_found  [1]  at least one master eligible
//                o_winner [2]  index of selected master
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [BUS_MASTER_CH-1:0]      i_elig,
    input  logic [BUS_MASTER_INDEX_W-1:0] i_start,
    output logic                          o_found,
    output logic [BUS_MASTER_INDEX_W-1:0] o_winner
);

    logic [BUS_MASTER_INDEX_W-1:0] w_idx;

    always_comb begin
        o_found  = 1'b0;
        o_winner = i_start;
        w_idx    = i_start;
        // Offset 4 wraps back to the start pointer itself, so the previous
        // owner is considered last.
        for (int k = 1; k <= BUS_MASTER_CH; k++) begin
            w_idx = i_start + BUS_MASTER_INDEX_W'(k);
            if (!o_found && i_elig[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin arbiter for the 4-master shared bus. Active-low
//                requests in, registered active-low grants out. Ownership is
//                held while the owner requests or is mid-burst; a slave-ready
//                watchdog revokes a stalled owner, masks it until it drops
//                its request, and pulses bus_err.
//  Ports       : clk, reset (async, active high)
//                m0..m3_req_   in   bus request, active low
//                m0..m3_busy   in   owner mid-burst, holds grant
//                s_rdy_        in   selected slave ready, active low
//                m0..m3_grnt_  out  bus grant, active low, registered
//                owner         out  current / last granted master
//                bus_err       out  one-cycle pulse on timeout revocation
//                err_id        out  index of revoked master
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    input  logic       m0_busy,
    input  logic       m1_busy,
    input  logic       m2_busy,
    input  logic       m3_busy,
    input  logic       s_rdy_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       bus_err,
    output logic [1:0] err_id
);

    localparam logic [TO_W-1:0] C_WD_LAST = TO_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    bus_arb_state_e                state_q,   state_d;
    logic [BUS_MASTER_INDEX_W-1:0] owner_q,   owner_d;
    logic [BUS_MASTER_CH-1:0]      grnt_q,    grnt_d;
    logic [BUS_MASTER_CH-1:0]      mask_q,    mask_d;
    logic [TO_W-1:0]               wd_q,      wd_d;
    logic                          bus_err_q, bus_err_d;
    logic [BUS_MASTER_INDEX_W-1:0] err_id_q,  err_id_d;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [BUS_MASTER_CH-1:0]      w_req;
    logic [BUS_MASTER_CH-1:0]      w_busy;
    logic [BUS_MASTER_CH-1:0]      w_pick_elig;
    logic                          w_found;
    logic [BUS_MASTER_INDEX_W-1:0] w_winner;
    logic                          w_release;
    logic                          w_wd_hit;

    assign w_req  = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign w_busy = {m3_busy, m2_busy, m1_busy, m0_busy};

    // While granted, a search only happens on release or timeout, and the
    // current owner must not win it back.
    assign w_pick_elig = (state_q == BUS_ARB_GRANT)
                       ? (w_req & ~mask_q & ~bus_onehot(owner_q))
                       : (w_req & ~mask_q);

    bus_arb_rr_pick u_pick (
        .i_elig   (w_pick_elig),
        .i_start  (owner_q),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    assign w_release = !w_req[owner_q] && !w_busy[owner_q];
    assign w_wd_hit  = (TIMEOUT != 0) && (state_q == BUS_ARB_GRANT)
                    && s_rdy_ && (wd_q == C_WD_LAST);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grnt_d    = grnt_q;
        wd_d      = wd_q;
        bus_err_d = 1'b0;
        err_id_d  = err_id_q;
        // A mask bit drops once its master is seen with its request released
        mask_d    = mask_q & w_req;

        case (state_q)
            BUS_ARB_IDLE: begin
                wd_d = '0;
                if (w_found) begin
                    state_d = BUS_ARB_GRANT;
                    owner_d = w_winner;
                    grnt_d  = ~bus_onehot(w_winner);
                end
            end

            BUS_ARB_GRANT: begin
                if (w_wd_hit || w_release) begin
                    // Timeout outranks both hold and a coincident release
                    if (w_wd_hit) begin
                        bus_err_d       = 1'b1;
                        err_id_d        = owner_q;
                        mask_d[owner_q] = 1'b1;
                    end
                    wd_d = '0;
                    if (w_found) begin
                        owner_d = w_winner;
                        grnt_d  = ~bus_onehot(w_winner);
                    end else begin
                        state_d = BUS_ARB_IDLE;
                        grnt_d  = {BUS_MASTER_CH{DISABLE_}};
                    end
                end else begin
                    wd_d = s_rdy_ ? (wd_q + TO_W'(1)) : '0;
                end
            end

            default: begin
                state_d = BUS_ARB_IDLE;
                grnt_d  = {BUS_MASTER_CH{DISABLE_}};
                wd_d    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BUS_ARB_IDLE;
            owner_q   <= 2'd3;  // first search begins at m0
            grnt_q    <= {BUS_MASTER_CH{DISABLE_}};
            mask_q    <= '0;
            wd_q      <= '0;
            bus_err_q <= 1'b0;
            err_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grnt_q    <= grnt_d;
            mask_q    <= mask_d;
            wd_q      <= wd_d;
            bus_err_q <= bus_err_d;
            err_id_q  <= err_id_d;
        end
    end

    assign m0_grnt_ = grnt_q[0];
    assign m1_grnt_ = grnt_q[1];
    assign m2_grnt_ = grnt_q[2];
    assign m3_grnt_ = grnt_q[3];
    assign owner    = owner_q;
    assign bus_err  = bus_err_q;
    assign err_id   = err_id_q;

endmodule
`default_nettype wire
